oam_dma_ctrl: RTL and testbench

Sequencer for the OAM DMA transfer triggered by CPU writes to the DMA register (FF46). On a write of value XX it copies 160 bytes from XX00–XX9F into OAM (FE00–FE9F). It owns the source-read and OAM-write ports for the duration of the transfer and flags bus ownership to the CPU-side decoder and the PPU. It replaces the passive FF46 storage inside the PPU register file.

---
 rtl/oam_dma_ctrl_if.sv | 24 ++
 rtl/oam_dma_ctrl.sv | 92 +++++++++
 tb/tb_oam_dma_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_if.sv
// oam_dma_ctrl_if: CPU-side MMIO bus plus DMA source-read and OAM-write ports of the OAM DMA sequencer
interface oam_dma_ctrl_if;
  logic [15:0] ADDR;
  logic        WR;
  logic        RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MMIO_DATA_in;
  logic        DMA_ACTIVE;
  logic        DMA_RD;
  logic [15:0] DMA_SRC_ADDR;
  logic [7:0]  DMA_SRC_DATA;
  logic        OAM_WR;
  logic [7:0]  OAM_ADDR;
  logic [7:0]  OAM_DATA;
  logic        CPU_BLOCK;
  modport slave (
    input  ADDR, WR, RD, MMIO_DATA_out, DMA_SRC_DATA,
    output MMIO_DATA_in, DMA_ACTIVE, DMA_RD, DMA_SRC_ADDR, OAM_WR, OAM_ADDR, OAM_DATA, CPU_BLOCK
  );
  modport master (
    output ADDR, WR, RD, MMIO_DATA_out, DMA_SRC_DATA,
    input  MMIO_DATA_in, DMA_ACTIVE, DMA_RD, DMA_SRC_ADDR, OAM_WR, OAM_ADDR, OAM_DATA, CPU_BLOCK
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: FF46-triggered OAM DMA sequencer copying OAM_BYTES bytes from page src_hi into OAM.
// Define OAM_DMA_CPU_BLOCK_EN to drive CPU_BLOCK while a transfer owns the bus.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          OAM_BYTES    = 160,
  parameter int          START_DELAY  = 1
) (
  input logic           clk,
  input logic           rst,
  oam_dma_ctrl_if.slave bus
);
  localparam logic [2:0] START_LAST = 3'(START_DELAY == 0 ? 0 : START_DELAY - 1);
  localparam logic [7:0] IDX_LAST   = 8'(OAM_BYTES - 1);
  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d, page_q, page_d, src_hi_q, src_hi_d, oam_addr_q, oam_addr_d;
  logic [15:0] src_addr_q, src_addr_d;
  logic        dma_rd_q, dma_rd_d, oam_wr_q, oam_wr_d;
  logic        trig, active, unused_rd;
  assign trig      = bus.WR && (bus.ADDR == DMA_REG_ADDR);
  assign unused_rd = bus.RD;
  // Outputs are registered from the next state so each strobe lines up with its state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    page_d   = page_q;
    src_hi_d = trig ? bus.MMIO_DATA_out : src_hi_q;
    if (trig) begin
      state_d = START;
      cnt_d   = 3'd0;
      idx_d   = 8'd0;
    end else begin
      unique case (state_q)
        START: begin
          state_d = (cnt_q == START_LAST) ? READ : START;
          cnt_d   = (cnt_q == START_LAST) ? cnt_q : cnt_q + 3'd1;
          page_d  = (cnt_q != START_LAST) ? page_q :
                    (src_hi_q < 8'hE0) ? src_hi_q : src_hi_q - 8'h20;
        end
        READ:  state_d = WRITE;
        WRITE: begin
          state_d = (idx_q == IDX_LAST) ? IDLE : READ;
          idx_d   = (idx_q == IDX_LAST) ? idx_q : idx_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    dma_rd_d   = (state_d == READ);
    src_addr_d = (state_d == READ) ? {page_d, idx_d} : 16'h0000;
    oam_wr_d   = (state_d == WRITE);
    oam_addr_d = (state_d == WRITE) ? idx_d : 8'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      idx_q      <= 8'd0;
      page_q     <= 8'd0;
      src_hi_q   <= 8'd0;
      dma_rd_q   <= 1'b0;
      src_addr_q <= 16'h0000;
      oam_wr_q   <= 1'b0;
      oam_addr_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      page_q     <= page_d;
      src_hi_q   <= src_hi_d;
      dma_rd_q   <= dma_rd_d;
      src_addr_q <= src_addr_d;
      oam_wr_q   <= oam_wr_d;
      oam_addr_q <= oam_addr_d;
    end
  end
  assign active           = (state_q != IDLE);
  assign bus.DMA_ACTIVE   = active;
  assign bus.DMA_RD       = dma_rd_q;
  assign bus.DMA_SRC_ADDR = src_addr_q;
  assign bus.OAM_WR       = oam_wr_q;
  assign bus.OAM_ADDR     = oam_addr_q;
  assign bus.OAM_DATA     = oam_wr_q ? bus.DMA_SRC_DATA : 8'h00;
  assign bus.MMIO_DATA_in = (bus.ADDR == DMA_REG_ADDR) ? src_hi_q : 8'hFF;
`ifdef OAM_DMA_CPU_BLOCK_EN
  assign bus.CPU_BLOCK = active && !(bus.ADDR >= 16'hFF80 && bus.ADDR <= 16'hFFFE) &&
                         (bus.ADDR != DMA_REG_ADDR);
`else
  assign bus.CPU_BLOCK = 1'b0;
`endif
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: randomized transfers checked against an event-list model of the DMA timeline
module tb_oam_dma_ctrl;
  localparam int N  = 160;
  localparam int SD = 1;
  localparam int FAR = 1 << 30;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  oam_dma_ctrl_if bus();
  oam_dma_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {int c; logic [15:0] a; logic [7:0] d;} ev_t;
  ev_t rd_log[$], wr_log[$], rd_exp[$], wr_exp[$];
  int cyc = 0, act_cnt = 0, n_chk = 0, n_fail = 0;
  logic [7:0] salt = 8'h00;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ salt;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.DMA_RD) bus.DMA_SRC_DATA <= src_byte(bus.DMA_SRC_ADDR);
  end

  always @(negedge clk) if (rst) begin
    if (bus.DMA_RD) rd_log.push_back({cyc, bus.DMA_SRC_ADDR, 8'h00});
    if (bus.OAM_WR) wr_log.push_back({cyc, 8'h00, bus.OAM_ADDR, bus.OAM_DATA});
    if (bus.DMA_ACTIVE) act_cnt++;
  end

  task automatic clear_logs;
    rd_log.delete(); wr_log.delete(); rd_exp.delete(); wr_exp.delete();
    act_cnt = 0;
  endtask

  task automatic wr_reg(input logic [7:0] v, output int t);
    bus.ADDR = 16'hFF46; bus.MMIO_DATA_out = v; bus.WR = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    bus.WR = 1'b0; bus.ADDR = 16'hC000;
  endtask

  // Expected reads/writes of a transfer triggered in cycle t, keeping only events up to cycle cut.
  task automatic add_xfer(input int t, input logic [7:0] v, input int cut);
    logic [7:0] p;
    p = (v < 8'hE0) ? v : v - 8'h20;
    for (int i = 0; i < N; i++) begin
      int rc;
      rc = t + 1 + SD + 2 * i;
      if (rc <= cut) rd_exp.push_back({rc, p, 8'(i), 8'h00});
      if (rc + 1 <= cut) wr_exp.push_back({rc + 1, 8'h00, 8'(i), src_byte({p, 8'(i)})});
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (bus.DMA_ACTIVE && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n >= 2000) begin n_fail++; $display("FAIL wait_idle: still active after %0d cycles", n); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.ADDR = 16'hFF40; bus.WR = 1'b0; bus.RD = 1'b0; bus.MMIO_DATA_out = 8'h00; bus.DMA_SRC_DATA = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.DMA_ACTIVE, bus.DMA_RD, bus.OAM_WR, bus.CPU_BLOCK, bus.DMA_SRC_ADDR, bus.OAM_ADDR, bus.OAM_DATA} !== 36'h0) begin
      n_fail++; $display("FAIL reset_outputs: act=%b rd=%b wr=%b blk=%b src=%h oa=%h od=%h, want all 0",
        bus.DMA_ACTIVE, bus.DMA_RD, bus.OAM_WR, bus.CPU_BLOCK, bus.DMA_SRC_ADDR, bus.OAM_ADDR, bus.OAM_DATA);
    end
    n_chk++;
    if (bus.MMIO_DATA_in !== 8'hFF) begin n_fail++; $display("FAIL reset_rd_ff40: got %h want ff", bus.MMIO_DATA_in); end
    bus.ADDR = 16'hFF46; #1;
    n_chk++;
    if (bus.MMIO_DATA_in !== 8'h00) begin n_fail++; $display("FAIL reset_rd_ff46: got %h want 00", bus.MMIO_DATA_in); end
    bus.ADDR = 16'hC000;
    @(posedge clk); #1;
  endtask

  task automatic test_transfer(input logic [7:0] v, input logic [7:0] s);
    int t;
    salt = s;
    clear_logs();
    wr_reg(v, t);
    add_xfer(t, v, FAR);
    wait_idle();
    n_chk++;
    if (rd_log.size() != rd_exp.size() || wr_log.size() != wr_exp.size()) begin
      n_fail++; $display("FAIL xfer_%h_count: rd=%0d wr=%0d want rd=%0d wr=%0d", v, rd_log.size(), wr_log.size(), rd_exp.size(), wr_exp.size());
    end
    foreach (rd_exp[i]) if (i < rd_log.size()) begin
      n_chk++;
      if (rd_log[i] !== rd_exp[i]) begin n_fail++; $display("FAIL xfer_%h_rd[%0d]: got %h want %h", v, i, rd_log[i], rd_exp[i]); end
    end
    foreach (wr_exp[i]) if (i < wr_log.size()) begin
      n_chk++;
      if (wr_log[i] !== wr_exp[i]) begin n_fail++; $display("FAIL xfer_%h_wr[%0d]: got %h want %h", v, i, wr_log[i], wr_exp[i]); end
    end
    n_chk++;
    if (act_cnt != SD + 2 * N) begin n_fail++; $display("FAIL xfer_%h_active: got %0d want %0d", v, act_cnt, SD + 2 * N); end
    bus.ADDR = 16'hFF46; #1;
    n_chk++;
    if (bus.MMIO_DATA_in !== v) begin n_fail++; $display("FAIL xfer_%h_readback: got %h want %h", v, bus.MMIO_DATA_in, v); end
    bus.ADDR = 16'hC000;
    @(posedge clk); #1;
  endtask

  task automatic test_retrigger(input int off);
    int t0, t1;
    salt = 8'($urandom);
    clear_logs();
    wr_reg(8'hC0, t0);
    repeat (off - 1) @(posedge clk);
    #1;
    wr_reg(8'hD0, t1);
    add_xfer(t0, 8'hC0, t1);
    add_xfer(t1, 8'hD0, FAR);
    wait_idle();
    n_chk++;
    if (rd_log.size() != rd_exp.size() || wr_log.size() != wr_exp.size()) begin
      n_fail++; $display("FAIL retrig_%0d_count: rd=%0d wr=%0d want rd=%0d wr=%0d", off, rd_log.size(), wr_log.size(), rd_exp.size(), wr_exp.size());
    end
    foreach (rd_exp[i]) if (i < rd_log.size()) begin
      n_chk++;
      if (rd_log[i] !== rd_exp[i]) begin n_fail++; $display("FAIL retrig_%0d_rd[%0d]: got %h want %h", off, i, rd_log[i], rd_exp[i]); end
    end
    foreach (wr_exp[i]) if (i < wr_log.size()) begin
      n_chk++;
      if (wr_log[i] !== wr_exp[i]) begin n_fail++; $display("FAIL retrig_%0d_wr[%0d]: got %h want %h", off, i, wr_log[i], wr_exp[i]); end
    end
    n_chk++;
    if (act_cnt != t1 - t0 + SD + 2 * N) begin
      n_fail++; $display("FAIL retrig_%0d_active: got %0d want %0d", off, act_cnt, t1 - t0 + SD + 2 * N);
    end
  endtask

  task automatic test_reset_mid;
    int t, n;
    salt = 8'($urandom);
    clear_logs();
    wr_reg(8'hC0, t);
    n = 0;
    while (!(bus.OAM_WR && bus.OAM_ADDR == 8'd80) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n >= 1000) begin n_fail++; $display("FAIL rstmid_reach: idx 80 not seen in %0d cycles", n); end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.DMA_ACTIVE, bus.DMA_RD, bus.OAM_WR, bus.CPU_BLOCK, bus.DMA_SRC_ADDR, bus.OAM_ADDR, bus.OAM_DATA} !== 36'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: act=%b rd=%b wr=%b blk=%b src=%h oa=%h od=%h, want all 0",
        bus.DMA_ACTIVE, bus.DMA_RD, bus.OAM_WR, bus.CPU_BLOCK, bus.DMA_SRC_ADDR, bus.OAM_ADDR, bus.OAM_DATA);
    end
    bus.ADDR = 16'hFF46; #1;
    n_chk++;
    if (bus.MMIO_DATA_in !== 8'h00) begin n_fail++; $display("FAIL rstmid_src_hi: got %h want 00", bus.MMIO_DATA_in); end
    bus.ADDR = 16'hC000;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    repeat (40) @(posedge clk);
    #1;
    n_chk++;
    if (wr_log.size() != 0 || rd_log.size() != 0 || act_cnt != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: wr=%0d rd=%0d act=%0d want 0 0 0", wr_log.size(), rd_log.size(), act_cnt);
    end
  endtask

  task automatic test_cpu_block;
    logic [15:0] addrs[7];
    logic [7:0] v;
    int t;
    logic e;
    addrs = '{16'hC000, 16'hFF90, 16'hFF46, 16'hFF80, 16'hFFFE, 16'hFFFF, 16'h8000};
    v = 8'($urandom);
    wr_reg(v, t);
    foreach (addrs[i]) begin
      bus.ADDR = addrs[i]; #1;
`ifdef OAM_DMA_CPU_BLOCK_EN
      e = (addrs[i] < 16'hFF80 || addrs[i] > 16'hFFFE) && addrs[i] != 16'hFF46;
`else
      e = 1'b0;
`endif
      n_chk++;
      if (bus.CPU_BLOCK !== e) begin n_fail++; $display("FAIL cpu_block_%h: got %b want %b", addrs[i], bus.CPU_BLOCK, e); end
    end
    bus.ADDR = 16'hFF46; #1;
    n_chk++;
    if (bus.MMIO_DATA_in !== v) begin n_fail++; $display("FAIL cpu_block_readback: got %h want %h", bus.MMIO_DATA_in, v); end
    bus.ADDR = 16'hC000;
    wait_idle();
    n_chk++;
    if (bus.CPU_BLOCK !== 1'b0) begin n_fail++; $display("FAIL cpu_block_idle: got %b want 0", bus.CPU_BLOCK); end
  endtask

  initial begin
    test_reset();
    test_transfer(8'hC1, 8'h00);
    test_transfer(8'hF0, 8'($urandom));
    for (int k = 0; k < 3; k++) test_transfer(8'($urandom), 8'($urandom));
    test_retrigger(51);
    test_retrigger(SD + 2 * N);
    test_retrigger($urandom_range(1, SD + 2 * N));
    test_reset_mid();
    test_cpu_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
